serial_paralelo1: RTL and testbench

//  Receive end of the serial lane: rebuilds bytes from the 1-bit stream sent LSB-first at clk_32f.

---
 rtl/serial_paralelo1_pkg.sv | 12 +
 rtl/serial_paralelo1.sv | 107 ++++++++++
 tb/tb_serial_paralelo1.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_paralelo1_pkg.sv
// rtl/serial_paralelo1_pkg.sv - shared comma symbol and receiver state encodings
package serial_paralelo1_pkg;

  localparam logic [7:0] COMMA_CHAR = 8'hBC;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/serial_paralelo1.sv
// rtl/serial_paralelo1.sv - serial lane receiver: comma hunt, sync count, byte rebuild at clk_32f
module serial_paralelo1
  import serial_paralelo1_pkg::*;
#(
  parameter logic [7:0] COMMA    = COMMA_CHAR,
  parameter int         BC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam logic [3:0] BC_MAX = 4'(BC_COUNT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_sh;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_nxt;
  logic [3:0] r_bc_cnt;
  logic [3:0] w_bc_cnt_nxt;
  logic [7:0] r_data_out;
  logic [7:0] w_data_nxt;
  logic       r_valid;
  logic       w_valid_nxt;
  logic [7:0] w_nxt;
  logic       w_byte_done;
  logic       w_is_comma;

  // Window including the bit sampled on this edge; LSB-first so new bits enter at the top
  assign w_nxt       = {data_in, r_sh[7:1]};
  assign w_byte_done = (r_bit_cnt == 3'd7);
  assign w_is_comma  = (w_nxt == COMMA);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      r_state    <= ST_HUNT;
      r_sh       <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_bc_cnt   <= 4'd0;
      r_data_out <= 8'h00;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sh       <= w_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_bc_cnt   <= w_bc_cnt_nxt;
      r_data_out <= w_data_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = ST_HUNT;
    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
    w_bc_cnt_nxt  = r_bc_cnt;
    w_data_nxt    = 8'h00;
    w_valid_nxt   = 1'b0;
    case (r_state)
      ST_HUNT: begin
        w_bit_cnt_nxt = 3'd0;
        w_bc_cnt_nxt  = 4'd0;
        if (w_is_comma) begin
          w_bc_cnt_nxt = 4'd1;
          if (BC_MAX == 4'd1) w_state_nxt = ST_LOCKED;
          else                w_state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        w_state_nxt = ST_SYNC;
        if (w_byte_done) begin
          if (!w_is_comma) begin
            w_state_nxt   = ST_HUNT;
            w_bc_cnt_nxt  = 4'd0;
            w_bit_cnt_nxt = 3'd0;
          end else if (r_bc_cnt + 4'd1 >= BC_MAX) begin
            w_state_nxt  = ST_LOCKED;
            w_bc_cnt_nxt = BC_MAX;
          end else begin
            w_bc_cnt_nxt = r_bc_cnt + 4'd1;
          end
        end
      end
      ST_LOCKED: begin
        w_state_nxt = ST_LOCKED;
        w_data_nxt  = r_data_out;
        w_valid_nxt = r_valid;
        if (w_byte_done) begin
          w_data_nxt  = w_nxt;
          w_valid_nxt = !w_is_comma;
        end
      end
      default: begin
        w_bit_cnt_nxt = 3'd0;
        w_bc_cnt_nxt  = 4'd0;
      end
    endcase
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid;
  assign active    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_serial_paralelo1.sv
// tb/tb_serial_paralelo1.sv - directed bench for the serial lane receiver
module tb_serial_paralelo1;
  import serial_paralelo1_pkg::*;

  logic       clk_32f;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  int n_tests;
  int n_fail;

  serial_paralelo1 dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one bit, let the edge take it, land 1 time unit after the edge
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic check_outs(input string tag, input logic [7:0] d, input logic v, input logic a);
    check({tag, ".data"},   {24'h0, data_out}, {24'h0, d});
    check({tag, ".valid"},  {31'h0, valid_out}, {31'h0, v});
    check({tag, ".active"}, {31'h0, active},    {31'h0, a});
  endtask

  // Four commas with the lock edge landing exactly on bit 7 of the last one
  task automatic lock_with_commas(input string tag);
    logic [7:0] c;
    c = COMMA_CHAR;
    for (int k = 0; k < 3; k++) begin
      send_byte(c);
      check({tag, ".pre_lock"}, {31'h0, active}, 32'h0);
    end
    for (int i = 0; i < 7; i++) send_bit(c[i]);
    check({tag, ".bit6_comma4"}, {31'h0, active}, 32'h0);
    send_bit(c[7]);
    check_outs({tag, ".locked"}, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    n_tests = 0;
    n_fail  = 0;
    data_in = 1'b0;
    reset   = 1'b1;

    // 1: reset held with toggling data
    for (int i = 0; i < 5; i++) begin
      send_bit(i[0]);
      check_outs("t1.reset", 8'h00, 1'b0, 1'b0);
    end
    reset = 1'b0;

    // 2: prefix bits then four commas
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    lock_with_commas("t2");

    // 3: payload A5 held for 8 cycles, then 3C
    send_byte(8'hA5);
    check_outs("t3.a5", 8'hA5, 1'b1, 1'b1);
    b = 8'h3C;
    for (int i = 0; i < 7; i++) begin
      send_bit(b[i]);
      check_outs("t3.hold_a5", 8'hA5, 1'b1, 1'b1);
    end
    send_bit(b[7]);
    check_outs("t3.3c", 8'h3C, 1'b1, 1'b1);

    // 4: comma between payload bytes
    b = COMMA_CHAR;
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (i < 7) check_outs("t4.hold_3c", 8'h3C, 1'b1, 1'b1);
    end
    check_outs("t4.comma", 8'hBC, 1'b0, 1'b1);
    b = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
      if (i < 7) check_outs("t4.hold_bc", 8'hBC, 1'b0, 1'b1);
    end
    check_outs("t4.5a", 8'h5A, 1'b1, 1'b1);

    // 5: broken sync falls back to hunt, then relocks
    reset = 1'b1;
    send_bit(1'b0);
    reset = 1'b0;
    check_outs("t5.reset", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    check({"t5.bc1"}, {31'h0, active}, 32'h0);
    send_byte(8'hBC);
    check({"t5.bc2"}, {31'h0, active}, 32'h0);
    send_byte(8'h00);
    check_outs("t5.bad", 8'h00, 1'b0, 1'b0);
    lock_with_commas("t5");
    send_byte(8'h81);
    check_outs("t5.81", 8'h81, 1'b1, 1'b1);

    // 6: async reset mid-byte while locked
    b = 8'hC3;
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    check_outs("t6.before", 8'h81, 1'b1, 1'b1);
    reset = 1'b1;
    #1;
    check_outs("t6.async", 8'h00, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    lock_with_commas("t6");
    send_byte(8'hC3);
    check_outs("t6.c3", 8'hC3, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
